// File: rtl/mhd_pair_gen_pkg.sv
// Shared types and mask/LFSR helpers for the Hamming-distance pair generator.
// Helpers work on 64-bit values; callers truncate to their word width.
package mhd_gen_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DIST_W    = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [63:0] lfsr_next(input logic [63:0] x, input logic [63:0] taps);
        return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
    endfunction

    function automatic logic [63:0] first_mask(input int unsigned k);
        return (64'd1 << k) - 64'd1;
    endfunction

    // Top k bits of a width-bit word set.
    function automatic logic [63:0] last_mask(input int unsigned k, input int unsigned width);
        return first_mask(k) << (width - k);
    endfunction

endpackage

// File: rtl/mhd_pair_gen_if.sv
// Pair stream from the generator to the miter: valid/ready with a, b and distance.
interface mhd_pair_gen_if #(
    parameter int WIDTH = 16,
    parameter int DW    = $clog2(WIDTH + 1)
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [DW-1:0]    out_dist;

    modport master (output out_valid, out_a, out_b, out_dist, input out_ready);
    modport slave  (input out_valid, out_a, out_b, out_dist, output out_ready);
endinterface

// File: rtl/mhd_pair_gen_next_comb.sv
// Gosper's step: next larger word with the same popcount. Shift by ctz instead of divide.
module mhd_next_comb #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] nxt
);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] c, r;
    logic [SW-1:0]    sh;

    assign c = m & (~m + 1'b1);
    assign r = m + c;

    // Priority encoder: descending scan so the lowest set bit of c wins.
    always_comb begin
        sh = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (c[i]) sh = SW'(i);
        end
    end

    assign nxt = (((r ^ m) >> 2) >> sh) | r;
endmodule

// File: rtl/mhd_pair_gen.sv
// Emits (a, a^mask) pairs with popcount(mask)==k, walking all masks per LFSR base word.
// Define MHD_PAIR_GEN_CHECK_EN to add the sticky chk_err self-check output.
module mhd_pair_gen
    import mhd_gen_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               NUM_BASE = 4,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter int               DW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    k,
    input  logic [WIDTH-1:0] seed,
    mhd_pair_gen_if.master   pif,
    output logic             busy,
    output logic             done,
`ifdef MHD_PAIR_GEN_CHECK_EN
    output logic             chk_err,
`endif
    output logic             cfg_err
);
    localparam int            BC_W = (NUM_BASE > 1) ? $clog2(NUM_BASE) : 1;
    localparam logic [DW-1:0] KMAX = DW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] base, mask;
    logic [BC_W-1:0]  base_cnt;
    logic [DW-1:0]    k_q;

    logic [WIDTH-1:0] first_m, last_m, nxt, base_nx, k_first, seed_nz;

    assign first_m = WIDTH'(first_mask(32'(k_q)));
    assign last_m  = WIDTH'(last_mask(32'(k_q), WIDTH));
    assign base_nx = WIDTH'(lfsr_next(64'(base), 64'(TAPS)));
    assign k_first = WIDTH'(first_mask(32'(k)));
    assign seed_nz = (seed == '0) ? WIDTH'(1) : seed;

    mhd_next_comb #(.WIDTH(WIDTH)) u_next (.m(mask), .nxt(nxt));

`ifdef MHD_PAIR_GEN_CHECK_EN
    logic [WIDTH-1:0] diff;
    logic [DW-1:0]    pop;
    assign diff = pif.out_a ^ pif.out_b;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + DW'(diff[i]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            mask          <= '0;
            base_cnt      <= '0;
            k_q           <= '0;
            pif.out_valid <= 1'b0;
            pif.out_a     <= '0;
            pif.out_b     <= '0;
            pif.out_dist  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
`ifdef MHD_PAIR_GEN_CHECK_EN
            chk_err       <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k > KMAX) begin
                            cfg_err <= 1'b1;
                        end else begin
                            base          <= seed_nz;
                            mask          <= k_first;
                            base_cnt      <= '0;
                            k_q           <= k;
                            pif.out_valid <= 1'b1;
                            pif.out_a     <= seed_nz;
                            pif.out_b     <= seed_nz ^ k_first;
                            pif.out_dist  <= k;
                            busy          <= 1'b1;
                            state         <= RUN;
`ifdef MHD_PAIR_GEN_CHECK_EN
                            chk_err       <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    // out_valid is always high here, so ready alone marks a transfer.
                    if (pif.out_ready) begin
`ifdef MHD_PAIR_GEN_CHECK_EN
                        if (pop != pif.out_dist) chk_err <= 1'b1;
`endif
                        if (mask != last_m) begin
                            mask      <= nxt;
                            pif.out_b <= base ^ nxt;
`ifdef MHD_PAIR_GEN_CHECK_EN
                            if (nxt <= mask) chk_err <= 1'b1;
`endif
                        end else if (base_cnt != BC_W'(NUM_BASE - 1)) begin
                            base      <= base_nx;
                            mask      <= first_m;
                            base_cnt  <= base_cnt + 1'b1;
                            pif.out_a <= base_nx;
                            pif.out_b <= base_nx ^ first_m;
                        end else begin
                            pif.out_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mhd_pair_gen.sv
// Directed bench: two DUTs (NUM_BASE=1 and 4) muxed onto one set of observation signals.
module tb_mhd_pair_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  k = '0;
    logic [15:0] seed = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mhd_pair_gen_if #(.WIDTH(16)) if1 ();
    mhd_pair_gen_if #(.WIDTH(16)) if4 ();
    assign if1.out_ready = ready & ~sel;
    assign if4.out_ready = ready & sel;

    logic busy1, done1, cerr1, busy4, done4, cerr4;
`ifdef MHD_PAIR_GEN_CHECK_EN
    logic chk1, chk4;
`endif

    mhd_pair_gen #(.WIDTH(16), .NUM_BASE(1), .TAPS(16'hB400)) u1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .k(k), .seed(seed), .pif(if1),
        .busy(busy1), .done(done1),
`ifdef MHD_PAIR_GEN_CHECK_EN
        .chk_err(chk1),
`endif
        .cfg_err(cerr1));

    mhd_pair_gen #(.WIDTH(16), .NUM_BASE(4), .TAPS(16'hB400)) u4 (
        .clk(clk), .rst(rst), .start(start & sel), .k(k), .seed(seed), .pif(if4),
        .busy(busy4), .done(done4),
`ifdef MHD_PAIR_GEN_CHECK_EN
        .chk_err(chk4),
`endif
        .cfg_err(cerr4));

    logic        vld, busy_m, done_m, cerr_m;
    logic [15:0] a, b;
    logic [4:0]  d;
    always_comb begin
        vld    = sel ? if4.out_valid : if1.out_valid;
        a      = sel ? if4.out_a     : if1.out_a;
        b      = sel ? if4.out_b     : if1.out_b;
        d      = sel ? if4.out_dist  : if1.out_dist;
        busy_m = sel ? busy4 : busy1;
        done_m = sel ? done4 : done1;
        cerr_m = sel ? cerr4 : cerr1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int popc(input logic [15:0] x);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(x[i]);
        return n;
    endfunction

    // Smallest mask above 'from' with popcount kk, or -1 when exhausted.
    function automatic int nextw(input int from, input int kk);
        for (int m = from + 1; m < 65536; m++) begin
            if (popc(m[15:0]) == kk) return m;
        end
        return -1;
    endfunction

    function automatic logic [15:0] lfsr_m(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [40:0] outs();
        return {vld, a, b, d, busy_m, done_m, cerr_m};
    endfunction

    // Start a run and consume it against the reference walk. rst_at>=0 resets after that many pairs.
    task automatic run(input string tag, input bit s, input int kk, input logic [15:0] sd,
                       input int nb, input bit rnd, input bit poke, input int rst_at,
                       input int exp_pairs);
        logic [15:0] base, pa, pb;
        logic [4:0]  pd;
        int m, nm, bcnt, npairs, nerr, serr;
        bit  mdone, stalled, got_done, rdy;
        npairs = 0; nerr = 0; serr = 0; mdone = 0; stalled = 0; got_done = 0;
        pa = '0; pb = '0; pd = '0;
        sel = s; k = 5'(kk); seed = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_lat"}, {63'd0, vld}, 64'd1);
        base = (sd == 16'd0) ? 16'd1 : sd;
        m = nextw(-1, kk);
        bcnt = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            if (stalled && (!vld || a != pa || b != pb || d != pd)) serr++;
            if (vld && (mdone || a != base || b != (base ^ m[15:0]) || d != 5'(kk))) nerr++;
            if (done_m) begin
                got_done = 1'b1;
                check({tag, "_done_busy"}, {62'd0, busy_m, vld}, 64'd0);
                if (poke) begin
                    start = 1'b1;
                    k = 5'(kk);
                end
                break;
            end
            if (rst_at >= 0 && npairs == rst_at) begin
                rst = 1'b1;
                break;
            end
            // Mid-run start with a different k must be ignored.
            start = poke && (cyc == 5);
            k = (poke && cyc == 5) ? 5'(kk + 1) : 5'(kk);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = rdy;
            if (vld && rdy) begin
                npairs++;
                nm = nextw(m, kk);
                if (nm >= 0) m = nm;
                else if (bcnt < nb - 1) begin
                    base = lfsr_m(base);
                    m = nextw(-1, kk);
                    bcnt++;
                end else mdone = 1'b1;
            end
            stalled = vld && !rdy;
            pa = a; pb = b; pd = d;
            @(posedge clk); #1;
        end
        ready = 1'b0;
        if (rst_at >= 0) begin
            @(posedge clk); #1;
            check({tag, "_rst_outs"}, {23'd0, outs()}, 64'd0);
            rst = 1'b0;
        end else begin
            check({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
            check({tag, "_pairs"}, 64'(npairs), 64'(exp_pairs));
            check({tag, "_data_err"}, 64'(nerr), 64'd0);
            if (rnd) check({tag, "_stall_err"}, 64'(serr), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_post1"}, {62'd0, done_m, vld}, 64'd0);
            @(posedge clk); #1;
            check({tag, "_post2"}, {62'd0, busy_m, vld}, 64'd0);
        end
`ifdef MHD_PAIR_GEN_CHECK_EN
        check({tag, "_chk_err"}, {63'd0, sel ? chk4 : chk1}, 64'd0);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        check("reset_u1", {23'd0, outs()}, 64'd0);
        sel = 1'b1;
        #1;
        check("reset_u4", {23'd0, outs()}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: k=0, seed 0 -> single pair a=b=1
        sel = 1'b0;
        #1;
        run("t1", 1'b0, 0, 16'h0000, 1, 1'b0, 1'b0, -1, 1);
        // 2: k=1 walks 16 single-bit masks; start pokes in RUN and DONE
        run("t2", 1'b0, 1, 16'hACE1, 1, 1'b0, 1'b1, -1, 16);
        // 3: k=9 over four LFSR bases, C(16,9)=11440 each
        run("t3", 1'b1, 9, 16'hACE1, 4, 1'b0, 1'b0, -1, 45760);

        // 4: k=17 rejected, then k=2 runs
        sel = 1'b0; k = 5'd17; seed = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_cfg_err", {61'd0, cerr_m, vld, busy_m}, 64'h4);
        @(posedge clk); #1;
        check("t4_cfg_clr", {61'd0, cerr_m, vld, busy_m}, 64'h0);
        run("t4b", 1'b0, 2, 16'h1234, 1, 1'b0, 1'b0, -1, 120);

        // 5: random backpressure, k=3, C(16,3)=560
        run("t5", 1'b0, 3, 16'hBEEF, 1, 1'b1, 1'b0, -1, 560);
        // 6: reset after 37 pairs of a k=4 run, then recover
        run("t6", 1'b1, 4, 16'h5A5A, 4, 1'b0, 1'b0, 37, 0);
        run("t6b", 1'b1, 0, 16'h0003, 4, 1'b0, 1'b0, -1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
